// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB and drives datapath selects.
// Latency: outputs decode combinationally from the current state plus IR fields; state advances each clock.
// Backpressure: none; every state lasts one cycle and the datapath is assumed always ready.
//
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_opcode, i_funct3, i_funct7b5      instruction register fields (valid from DECODE onward)
//   i_zero                              ALU zero flag (only used by BEQ for the PC enable)
//   o_pcWrite, o_irWrite, o_memWrite,
//   o_regWrite                          datapath write enables (all forced low during reset)
//   o_adrSrc                            memory address select, 0 = PC, 1 = ALU output register
//   o_resultSrc, o_aluSrcA, o_aluSrcB,
//   o_aluControl                        datapath selects, encodings from riscv_pkg
//   o_immSrc                            immediate format, combinational from i_opcode
//   o_illegal                           one-cycle pulse in DECODE for an unsupported instruction
//   o_state                             current FSM state, for debug

package riscv_pkg;
  typedef enum logic [6:0] {
    OP_LW         = 7'b0000011,
    OP_SW         = 7'b0100011,
    OP_R_TYPE_ALU = 7'b0110011,
    OP_I_TYPE_ALU = 7'b0010011,
    OP_B_TYPE     = 7'b1100011,
    OP_JAL        = 7'b1101111
  } opcode_t;

  // {funct7b5, funct3}
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b1000,
    ALU_SLT = 4'b0010,
    ALU_XOR = 4'b0100,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU_OUTPUT_REG = 2'd0,
    RES_DATA_REG       = 2'd1,
    RES_ALU            = 2'd2
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC              = 2'd0,
    SRCA_OLD_PC          = 2'd1,
    SRCA_REG_READ_DATA_1 = 2'd2
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REG_READ_DATA_2    = 2'd0,
    SRCB_IMMEDIATE_EXTENDED = 2'd1,
    SRCB_FOUR               = 2'd2
  } alu_src_b_t;
endpackage

module riscv_multicycle_controller
  import riscv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [3:0] o_aluControl,
  output logic [1:0] o_immSrc,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t  state, next_state;
  alu_op_t alu_dec;
  logic    alu_f3_bad;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FETCH;
    else       state <= next_state;
  end

  assign o_state = state;

  // ALU operation from funct3; SUB needs both the R-type opcode and funct7b5,
  // so an ADDI whose immediate happens to set bit 30 stays an add.
  always_comb begin
    alu_dec    = ALU_ADD;
    alu_f3_bad = 1'b0;
    case (i_funct3)
      3'b000: if (i_opcode == OP_R_TYPE_ALU && i_funct7b5) alu_dec = ALU_SUB;
      3'b010: alu_dec = ALU_SLT;
      3'b100: alu_dec = ALU_XOR;
      3'b110: alu_dec = ALU_OR;
      3'b111: alu_dec = ALU_AND;
      default: alu_f3_bad = 1'b1;
    endcase
  end

  always_comb begin
    o_immSrc = 2'b00;
    case (i_opcode)
      OP_LW, OP_I_TYPE_ALU: o_immSrc = 2'b00;
      OP_SW:                o_immSrc = 2'b01;
      OP_B_TYPE:            o_immSrc = 2'b10;
      OP_JAL:               o_immSrc = 2'b11;
      default:              o_immSrc = 2'b00;
    endcase
  end

  always_comb begin
    next_state   = S_FETCH;
    o_pcWrite    = 1'b0;
    o_adrSrc     = 1'b0;
    o_memWrite   = 1'b0;
    o_irWrite    = 1'b0;
    o_regWrite   = 1'b0;
    o_illegal    = 1'b0;
    o_resultSrc  = RES_ALU_OUTPUT_REG;
    o_aluSrcA    = SRCA_PC;
    o_aluSrcB    = SRCB_REG_READ_DATA_2;
    o_aluControl = ALU_ADD;

    case (state)
      S_FETCH: begin
        o_irWrite   = 1'b1;
        o_pcWrite   = 1'b1;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSrc = RES_ALU;
        next_state  = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BEQ can use the ALU for the compare.
        o_aluSrcA = SRCA_OLD_PC;
        o_aluSrcB = SRCB_IMMEDIATE_EXTENDED;
        case (i_opcode)
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_R_TYPE_ALU: if (alu_f3_bad) o_illegal = 1'b1; else next_state = S_EXECUTER;
          OP_I_TYPE_ALU: if (alu_f3_bad) o_illegal = 1'b1; else next_state = S_EXECUTEI;
          OP_B_TYPE:     next_state = S_BEQ;
          OP_JAL:        next_state = S_JAL;
          default:       o_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA  = SRCA_REG_READ_DATA_1;
        o_aluSrcB  = SRCB_IMMEDIATE_EXTENDED;
        next_state = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adrSrc   = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc = RES_DATA_REG;
        o_regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrSrc   = 1'b1;
        o_memWrite = 1'b1;
      end
      S_EXECUTER: begin
        o_aluSrcA    = SRCA_REG_READ_DATA_1;
        o_aluSrcB    = SRCB_REG_READ_DATA_2;
        o_aluControl = alu_dec;
        next_state   = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_aluSrcA    = SRCA_REG_READ_DATA_1;
        o_aluSrcB    = SRCB_IMMEDIATE_EXTENDED;
        o_aluControl = alu_dec;
        next_state   = S_ALUWB;
      end
      S_ALUWB: o_regWrite = 1'b1;
      S_BEQ: begin
        // Only Mealy term: the PC loads the precomputed target when the compare is equal.
        o_aluSrcA    = SRCA_REG_READ_DATA_1;
        o_aluSrcB    = SRCB_REG_READ_DATA_2;
        o_aluControl = ALU_SUB;
        o_pcWrite    = (i_funct3 == 3'b000) && i_zero;
      end
      S_JAL: begin
        // PC takes the target held in the ALU output register while the ALU forms
        // the link value PC+4 for ALUWB.
        o_aluSrcA  = SRCA_OLD_PC;
        o_aluSrcB  = SRCB_FOUR;
        o_pcWrite  = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase

    if (i_rst) begin
      o_pcWrite  = 1'b0;
      o_irWrite  = 1'b0;
      o_memWrite = 1'b0;
      o_regWrite = 1'b0;
      o_illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
module tb_riscv_multicycle_controller;
  import riscv_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite, o_illegal;
  logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
  logic [3:0] o_aluControl, o_state;

  int total = 0;
  int bad   = 0;

  typedef logic [21:0] vec_t;

  riscv_multicycle_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc),
    .o_memWrite(o_memWrite), .o_irWrite(o_irWrite), .o_regWrite(o_regWrite),
    .o_resultSrc(o_resultSrc), .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB),
    .o_aluControl(o_aluControl), .o_immSrc(o_immSrc), .o_illegal(o_illegal), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Packed view {state, pcW, adrSrc, memW, irW, regW, resultSrc, srcA, srcB, aluCtl, immSrc, illegal}
  function automatic vec_t f(input logic [3:0] st, input logic pcw, input logic adr,
                             input logic mw, input logic irw, input logic rw,
                             input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                             input logic [3:0] alu, input logic [1:0] imm, input logic ill);
    return {st, pcw, adr, mw, irw, rw, res, a, b, alu, imm, ill};
  endfunction

  function automatic vec_t obs();
    return {o_state, o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite,
            o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluControl, o_immSrc, o_illegal};
  endfunction

  function automatic vec_t fetch_v(input logic [1:0] imm);
    return f(4'd0, 1, 0, 0, 1, 0, RES_ALU, SRCA_PC, SRCB_FOUR, ALU_ADD, imm, 0);
  endfunction

  function automatic vec_t decode_v(input logic [1:0] imm, input logic ill);
    return f(4'd1, 0, 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_OLD_PC, SRCB_IMMEDIATE_EXTENDED,
             ALU_ADD, imm, ill);
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    i_opcode   = op;
    i_funct3   = f3;
    i_funct7b5 = f7;
    #1;
  endtask

  task automatic test_reset();
    vec_t e;
    i_rst = 1'b1;
    i_zero = 1'b0;
    set_ir(OP_SW, 3'b010, 1'b0);
    e = f(4'd0, 0, 0, 0, 0, 0, RES_ALU, SRCA_PC, SRCB_FOUR, ALU_ADD, 2'b01, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL reset cyc%0d got=%h want=%h", k, obs(), e);
      end
    end
    i_rst = 1'b0;
    #1;
    total++;
    if (obs() !== fetch_v(2'b01)) begin
      bad++;
      $display("FAIL reset_first_fetch got=%h want=%h", obs(), fetch_v(2'b01));
    end
  endtask

  task automatic test_lw();
    vec_t ev[$];
    set_ir(OP_LW, 3'b010, 1'b0);
    ev.push_back(fetch_v(2'b00));
    ev.push_back(decode_v(2'b00, 0));
    ev.push_back(f(4'd2, 0, 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_REG_READ_DATA_1,
                   SRCB_IMMEDIATE_EXTENDED, ALU_ADD, 2'b00, 0));
    ev.push_back(f(4'd3, 0, 1, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
                   ALU_ADD, 2'b00, 0));
    ev.push_back(f(4'd4, 0, 0, 0, 0, 1, RES_DATA_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
                   ALU_ADD, 2'b00, 0));
    foreach (ev[k]) begin
      total++;
      if (obs() !== ev[k]) begin
        bad++;
        $display("FAIL lw cyc%0d got=%h want=%h", k, obs(), ev[k]);
      end
      step();
    end
  endtask

  task automatic test_sw();
    vec_t ev[$];
    set_ir(OP_SW, 3'b010, 1'b0);
    ev.push_back(fetch_v(2'b01));
    ev.push_back(decode_v(2'b01, 0));
    ev.push_back(f(4'd2, 0, 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_REG_READ_DATA_1,
                   SRCB_IMMEDIATE_EXTENDED, ALU_ADD, 2'b01, 0));
    ev.push_back(f(4'd5, 0, 1, 1, 0, 0, RES_ALU_OUTPUT_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
                   ALU_ADD, 2'b01, 0));
    foreach (ev[k]) begin
      total++;
      if (obs() !== ev[k]) begin
        bad++;
        $display("FAIL sw cyc%0d got=%h want=%h", k, obs(), ev[k]);
      end
      step();
    end
  endtask

  task automatic test_rtype_sub();
    vec_t ev[$];
    set_ir(OP_R_TYPE_ALU, 3'b000, 1'b1);
    ev.push_back(fetch_v(2'b00));
    ev.push_back(decode_v(2'b00, 0));
    ev.push_back(f(4'd6, 0, 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_REG_READ_DATA_1,
                   SRCB_REG_READ_DATA_2, ALU_SUB, 2'b00, 0));
    ev.push_back(f(4'd8, 0, 0, 0, 0, 1, RES_ALU_OUTPUT_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
                   ALU_ADD, 2'b00, 0));
    foreach (ev[k]) begin
      total++;
      if (obs() !== ev[k]) begin
        bad++;
        $display("FAIL rtype_sub cyc%0d got=%h want=%h", k, obs(), ev[k]);
      end
      step();
    end
  endtask

  task automatic test_itype_add();
    vec_t ev[$];
    set_ir(OP_I_TYPE_ALU, 3'b000, 1'b1);
    ev.push_back(fetch_v(2'b00));
    ev.push_back(decode_v(2'b00, 0));
    ev.push_back(f(4'd7, 0, 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_REG_READ_DATA_1,
                   SRCB_IMMEDIATE_EXTENDED, ALU_ADD, 2'b00, 0));
    ev.push_back(f(4'd8, 0, 0, 0, 0, 1, RES_ALU_OUTPUT_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
                   ALU_ADD, 2'b00, 0));
    foreach (ev[k]) begin
      total++;
      if (obs() !== ev[k]) begin
        bad++;
        $display("FAIL itype_add cyc%0d got=%h want=%h", k, obs(), ev[k]);
      end
      step();
    end
  endtask

  // Execute-state ALU control for a few other funct3 values.
  task automatic test_alu_decode();
    logic [6:0] ops[4]  = '{OP_R_TYPE_ALU, OP_I_TYPE_ALU, OP_R_TYPE_ALU, OP_R_TYPE_ALU};
    logic [2:0] f3s[4]  = '{3'b111, 3'b100, 3'b010, 3'b110};
    logic [3:0] want[4] = '{4'b0111, 4'b0100, 4'b0010, 4'b0110};
    logic [3:0] sts[4]  = '{4'd6, 4'd7, 4'd6, 4'd6};
    for (int i = 0; i < 4; i++) begin
      set_ir(ops[i], f3s[i], 1'b0);
      step();
      step();
      total++;
      if (o_state !== sts[i] || o_aluControl !== want[i]) begin
        bad++;
        $display("FAIL alu_decode idx%0d got state=%0d alu=%b want state=%0d alu=%b",
                 i, o_state, o_aluControl, sts[i], want[i]);
      end
      step();
      step();
    end
  endtask

  task automatic test_beq();
    vec_t ev[$];
    for (int z = 0; z < 2; z++) begin
      ev.delete();
      i_zero = z[0];
      set_ir(OP_B_TYPE, 3'b000, 1'b0);
      ev.push_back(fetch_v(2'b10));
      ev.push_back(decode_v(2'b10, 0));
      ev.push_back(f(4'd9, z[0], 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_REG_READ_DATA_1,
                     SRCB_REG_READ_DATA_2, ALU_SUB, 2'b10, 0));
      ev.push_back(fetch_v(2'b10));
      foreach (ev[k]) begin
        total++;
        if (obs() !== ev[k]) begin
          bad++;
          $display("FAIL beq z=%0d cyc%0d got=%h want=%h", z, k, obs(), ev[k]);
        end
        if (k < 3) step();
      end
    end
    i_zero = 1'b0;
  endtask

  task automatic test_jal();
    vec_t ev[$];
    set_ir(OP_JAL, 3'b000, 1'b0);
    ev.push_back(fetch_v(2'b11));
    ev.push_back(decode_v(2'b11, 0));
    ev.push_back(f(4'd10, 1, 0, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_OLD_PC, SRCB_FOUR,
                   ALU_ADD, 2'b11, 0));
    ev.push_back(f(4'd8, 0, 0, 0, 0, 1, RES_ALU_OUTPUT_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
                   ALU_ADD, 2'b11, 0));
    foreach (ev[k]) begin
      total++;
      if (obs() !== ev[k]) begin
        bad++;
        $display("FAIL jal cyc%0d got=%h want=%h", k, obs(), ev[k]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops[2] = '{7'b0110111, OP_R_TYPE_ALU};
    logic [2:0] f3s[2] = '{3'b000, 3'b001};
    vec_t ev[$];
    for (int i = 0; i < 2; i++) begin
      ev.delete();
      set_ir(ops[i], f3s[i], 1'b0);
      ev.push_back(fetch_v(2'b00));
      ev.push_back(decode_v(2'b00, 1));
      ev.push_back(fetch_v(2'b00));
      foreach (ev[k]) begin
        total++;
        if (obs() !== ev[k]) begin
          bad++;
          $display("FAIL illegal idx%0d cyc%0d got=%h want=%h", i, k, obs(), ev[k]);
        end
        if (k < 2) step();
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t e;
    set_ir(OP_SW, 3'b010, 1'b0);
    step();
    step();
    step();
    i_rst = 1'b1;
    #1;
    e = f(4'd5, 0, 1, 0, 0, 0, RES_ALU_OUTPUT_REG, SRCA_PC, SRCB_REG_READ_DATA_2,
          ALU_ADD, 2'b01, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_mid_memwrite got=%h want=%h", obs(), e);
    end
    step();
    e = f(4'd0, 0, 0, 0, 0, 0, RES_ALU, SRCA_PC, SRCB_FOUR, ALU_ADD, 2'b01, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_mid_fetch got=%h want=%h", obs(), e);
    end
    i_rst = 1'b0;
    #1;
    total++;
    if (obs() !== fetch_v(2'b01)) begin
      bad++;
      $display("FAIL reset_mid_release got=%h want=%h", obs(), fetch_v(2'b01));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_sub();
    test_itype_add();
    test_alu_decode();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
# riscv_multicycle_controller

Control unit for the multi-cycle RV32I core. It sequences every instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath selects and write enables: the result, ALU-input and ALU-operation selects use the shared package enums, alongside the PC, IR, memory and register-file enables. Its inputs come from the instruction register (opcode, funct3, funct7 bit 5) and the ALU zero flag.

## Interface
- No parameters. Encodings come from the shared package: opcodes, ALU op, result select, ALU input 1 and ALU input 2 selects.
- i_clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset.
- i_opcode  in  7  IR[6:0].
- i_funct3  in  3  IR[14:12].
- i_funct7b5  in  1  IR[30].
- i_zero  in  1  ALU zero flag, combinational from the current ALU inputs.
- o_pcWrite  out  1  PC register enable.
- o_adrSrc  out  1  memory address select: 0 = PC, 1 = ALU output register.
- o_memWrite  out  1  data memory write enable.
- o_irWrite  out  1  IR and old-PC register enable.
- o_regWrite  out  1  register-file write enable.
- o_resultSrc  out  2  result select (ALU_OUTPUT_REG / DATA_REG / ALU).
- o_aluSrcA  out  2  ALU input 1 select (PC / OLD_PC / REG_READ_DATA_1).
- o_aluSrcB  out  2  ALU input 2 select (REG_READ_DATA_2 / IMMEDIATE_EXTENDED / FOUR).
- o_aluControl  out  4  ALU operation, {funct7b5, funct3} encoding.
- o_immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- o_illegal  out  1  one-cycle pulse in DECODE for an unsupported instruction.
- o_state  out  4  current state, for debug.

## Operation
- Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL. The only Mealy term is o_pcWrite in BEQ.
- Defaults in every state unless listed below:
  - all enables 0, o_adrSrc = 0;
  - o_resultSrc = ALU_OUTPUT_REG, o_aluSrcA = PC, o_aluSrcB = REG_READ_DATA_2, o_aluControl = ADD.
- Per-state outputs:
  - FETCH: irWrite = 1, A = PC, B = FOUR, ADD, resultSrc = ALU, pcWrite = 1.
  - DECODE: A = OLD_PC, B = IMMEDIATE_EXTENDED, ADD (precomputes the branch target).
  - MEMADR: A = REG_READ_DATA_1, B = IMMEDIATE_EXTENDED, ADD.
  - MEMREAD: adrSrc = 1.
  - MEMWB: resultSrc = DATA_REG, regWrite = 1.
  - MEMWRITE: adrSrc = 1, memWrite = 1.
  - EXECUTER: A = REG_READ_DATA_1, B = REG_READ_DATA_2, decoded ALU op.
  - EXECUTEI: A = REG_READ_DATA_1, B = IMMEDIATE_EXTENDED, decoded ALU op.
  - ALUWB: regWrite = 1.
  - BEQ: A = REG_READ_DATA_1, B = REG_READ_DATA_2, SUB, pcWrite = i_zero when funct3 = 000, otherwise 0.
  - JAL: A = OLD_PC, B = FOUR, ADD, pcWrite = 1. The PC takes the target held in the ALU output register; the register file later gets PC+4.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by opcode: LW or SW → MEMADR; R_TYPE_ALU → EXECUTER; I_TYPE_ALU → EXECUTEI; B_TYPE → BEQ; JAL → JAL.
  - DECODE, unsupported instruction → FETCH with o_illegal = 1.
  - MEMADR → MEMREAD for LW, MEMWRITE for SW.
  - MEMREAD → MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
- ALU decode from funct3:
  - 000: SUB only if opcode is R_TYPE_ALU and funct7b5 = 1, otherwise ADD.
  - 010 → SLT, 100 → XOR, 110 → OR, 111 → AND.
  - 001, 011, 101 are unsupported for ALU opcodes: illegal.
- o_immSrc is combinational from i_opcode in all states:
  - I for LW and I_TYPE_ALU;
  - S for SW;
  - B for B_TYPE;
  - J for JAL;
  - 00 otherwise.

## Timing
- Reset: while i_rst = 1, o_pcWrite, o_irWrite, o_memWrite, o_regWrite and o_illegal are forced to 0. The first clock edge with i_rst high loads FETCH, so o_state = 0 after reset.
- The first cycle after i_rst deasserts is FETCH.
- Reset mid-instruction: the instruction is aborted on the next edge and no write enable is asserted while reset is high.
- Cycles per instruction, FETCH through last state: LW 5, SW 4, R-type 4, I-type 4, B-type 3, JAL 4, illegal 2.
- State changes only on rising i_clk; all outputs decode from the current state plus IR fields and i_zero.
- i_opcode, i_funct3 and i_funct7b5 are valid from DECODE onward. They are ignored in FETCH because the IR loads at the end of FETCH.

## Test plan
- Hold i_rst for 2 cycles, then release:
  - o_state = FETCH;
  - no enables asserted during reset;
  - the first post-reset cycle has irWrite = 1, pcWrite = 1, aluSrcB = FOUR.
- LW (opcode 0000011, funct3 010):
  - states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles;
  - o_adrSrc = 1 in MEMREAD;
  - regWrite = 1 with resultSrc = DATA_REG only in MEMWB;
  - o_immSrc = 00.
- R-type, funct3 000, funct7b5 = 1: o_aluControl = SUB in EXECUTER, regWrite = 1 in ALUWB.
- Same fields as I-type: o_aluControl = ADD, aluSrcB = IMMEDIATE_EXTENDED.
- B_TYPE, funct3 000:
  - i_zero = 1 gives o_pcWrite = 1 in BEQ;
  - i_zero = 0 gives o_pcWrite = 0;
  - both cases return to FETCH after 3 cycles.
- JAL: states FETCH, DECODE, JAL, ALUWB, with o_immSrc = 11 and pcWrite = 1 in JAL.
- Opcode 0110111:
  - o_illegal pulses for 1 cycle in DECODE and the next state is FETCH;
  - an R-type with funct3 001 produces the same pulse.
- Assert i_rst during MEMWRITE: memWrite = 0 and FETCH on the next edge.
